// File: rtl/instr_mem_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_pkg
//   Shared definitions for the instruction-memory loader: default depth,
//   bytes per word, the loader state encoding and a byte-lane insert helper.
//   CHECK is always declared so the encoding is the same whether or not the
//   checksum feature (INSTR_LOADER_CHECKSUM_EN) is compiled in.
// ---------------------------------------------------------------------------
package imem_pkg;

  localparam int IMEM_DEPTH = 13;
  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE,
    ASSEMBLE,
    WRITE,
    CHECK,
    DONE
  } loader_state_t;

  // Replace byte lane idx of w with b (little-endian lane numbering).
  function automatic logic [31:0] put_byte(input logic [31:0] w,
                                           input logic [1:0]  idx,
                                           input logic [7:0]  b);
    logic [31:0] r;
    r = w;
    r[{idx, 3'b000} +: 8] = b;
    return r;
  endfunction

endpackage

// File: rtl/instr_mem_loader_byte_packer.sv
// ---------------------------------------------------------------------------
// byte_packer
//   Packs an accepted byte stream into 32-bit little-endian words. Used by
//   the loader for program words and, when enabled, for the checksum word.
//
//   clk, reset    : clock, synchronous active-high reset
//   clear_i       : restart packing at byte lane 0
//   accept_i      : byte_i is consumed on this edge
//   byte_i        : incoming byte
//   word_o        : lane register (complete after the 4th accept)
//   word_nxt_o    : lane register with byte_i merged into the current lane;
//                   equals the finished word in the cycle of the 4th accept
//   word_ready_o  : pulse, the current accept completes a word
// ---------------------------------------------------------------------------
module byte_packer
  import imem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic [31:0] word_nxt_o,
  output logic        word_ready_o
);

  localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

  logic [1:0]  idx_q;
  logic [31:0] word_q;

  assign word_nxt_o   = put_byte(word_q, idx_q, byte_i);
  assign word_ready_o = accept_i && (idx_q == LAST_IDX);
  assign word_o       = word_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (clear_i) begin
      idx_q  <= '0;
    end else if (accept_i) begin
      word_q <= word_nxt_o;
      // Two-bit index wraps from the last lane back to 0 by itself.
      idx_q  <= idx_q + 2'd1;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// ---------------------------------------------------------------------------
// instr_mem_loader
//   Writer side of the instruction memory. Accepts a byte stream over a
//   valid/ready handshake, packs 4 bytes per word (LSB first) and writes
//   words sequentially into a registered memory array read by fetch.
//   fetch_enable stays low until the whole program is written.
//
//   Optional feature macro: INSTR_LOADER_CHECKSUM_EN
//     When defined, a running XOR of the written words is compared against
//     a 4-byte checksum word sent after the last program word.
//
//   Ports
//     clk, reset          : clock, synchronous active-high reset
//     start               : begin a load (honoured in IDLE / DONE only)
//     in_valid, in_byte   : byte stream input
//     in_ready            : byte accepted on edges with in_valid && in_ready
//     instruction_memory  : DEPTH x 32-bit registered memory
//     word_count          : words written in the current load
//     loading             : load in progress
//     load_done           : program fully written
//     fetch_enable        : fetch stage may read the memory
//     checksum_err        : checksum mismatch (0 without the feature)
// ---------------------------------------------------------------------------
module instr_mem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         in_valid,
  input  logic [7:0]                   in_byte,
  output logic                         in_ready,
  output logic [31:0]                  instruction_memory [DEPTH],
  output logic [$clog2(DEPTH+1)-1:0]   word_count,
  output logic                         loading,
  output logic                         load_done,
  output logic                         fetch_enable,
  output logic                         checksum_err
);

  localparam int            CW        = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] LAST_WORD = CW'(DEPTH - 1);

  loader_state_t state_q;
  logic [31:0]   mem_q [DEPTH];
  logic [CW-1:0] wc_q;
  logic          in_ready_q;
  logic          loading_q;
  logic          done_q;
  logic          fetch_q;

  logic          accept;
  logic          pk_clear;
  logic          pk_ready;
  logic [31:0]   pk_word;
  logic [31:0]   pk_word_nxt;

  // in_ready is a register, so acceptance never depends combinationally on
  // in_valid from the upstream side.
  assign accept   = in_valid && in_ready_q;
  assign pk_clear = start && ((state_q == IDLE) || (state_q == DONE));

  byte_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (pk_clear),
    .accept_i     (accept),
    .byte_i       (in_byte),
    .word_o       (pk_word),
    .word_nxt_o   (pk_word_nxt),
    .word_ready_o (pk_ready)
  );

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [31:0] xor_q;
  logic        err_q;
`else
  // The merged word is only needed to compare the checksum.
  logic [31:0] unused_word_nxt;
  assign unused_word_nxt = pk_word_nxt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wc_q       <= '0;
      in_ready_q <= 1'b0;
      loading_q  <= 1'b0;
      done_q     <= 1'b0;
      fetch_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      xor_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        // Memory is not cleared on a new load; entries are overwritten.
        IDLE, DONE: begin
          if (start) begin
            state_q    <= ASSEMBLE;
            wc_q       <= '0;
            in_ready_q <= 1'b1;
            loading_q  <= 1'b1;
            done_q     <= 1'b0;
            fetch_q    <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            xor_q      <= '0;
            err_q      <= 1'b0;
`endif
          end
        end

        ASSEMBLE: begin
          if (pk_ready) begin
            state_q    <= WRITE;
            in_ready_q <= 1'b0;
          end
        end

        WRITE: begin
          for (int i = 0; i < DEPTH; i++)
            if (wc_q == CW'(i)) mem_q[i] <= pk_word;
          wc_q <= wc_q + 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
          xor_q <= xor_q ^ pk_word;
`endif
          if (wc_q == LAST_WORD) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
            state_q    <= CHECK;
            in_ready_q <= 1'b1;
`else
            state_q    <= DONE;
            in_ready_q <= 1'b0;
            loading_q  <= 1'b0;
            done_q     <= 1'b1;
            fetch_q    <= 1'b1;
`endif
          end else begin
            state_q    <= ASSEMBLE;
            in_ready_q <= 1'b1;
          end
        end

`ifdef INSTR_LOADER_CHECKSUM_EN
        // The 4th checksum byte is still on the input, so compare the
        // merged word rather than the lane register.
        CHECK: begin
          if (pk_ready) begin
            state_q    <= DONE;
            in_ready_q <= 1'b0;
            loading_q  <= 1'b0;
            done_q     <= 1'b1;
            err_q      <= (pk_word_nxt != xor_q);
            fetch_q    <= (pk_word_nxt == xor_q);
          end
        end
`endif

        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
          loading_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready           = in_ready_q;
  assign instruction_memory = mem_q;
  assign word_count         = wc_q;
  assign loading            = loading_q;
  assign load_done          = done_q;
  assign fetch_enable       = fetch_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
  assign checksum_err       = err_q;
`else
  assign checksum_err       = 1'b0;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: a byte-count based reference model runs beside
// the DUT and every cycle's outputs are compared against it, plus literal
// expectations for the directed scenarios.
module tb_instr_mem_loader;

  localparam int DEPTH = 13;
`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        in_ready;
  logic [31:0] imem [DEPTH];
  logic [3:0]  word_count;
  logic        loading, load_done, fetch_enable, checksum_err;

  instr_mem_loader #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_byte(in_byte), .in_ready(in_ready), .instruction_memory(imem),
    .word_count(word_count), .loading(loading), .load_done(load_done),
    .fetch_enable(fetch_enable), .checksum_err(checksum_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 0;
  bit noise  = 0;
  bit mark_first = 0;
  int first_cyc = 0;
  int done_cyc  = 0;
  logic [31:0] prog [DEPTH];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the load as "bytes accepted so far" plus one pending write slot.
  bit          m_active = 0, m_pend = 0, m_done = 0, m_err = 0;
  int          m_wc = 0, m_bytes = 0;
  logic [7:0]  m_buf [4];
  logic [31:0] m_mem [DEPTH];

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_active = 0; m_pend = 0; m_done = 0; m_err = 0; m_wc = 0; m_bytes = 0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1; m_pend = 0; m_done = 0; m_err = 0; m_wc = 0; m_bytes = 0;
      end
    end else if (m_pend) begin
      m_mem[m_wc] = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
      m_wc++;
      m_pend = 0;
      if (m_wc == DEPTH && !CK) begin m_active = 0; m_done = 1; end
    end else if (in_valid) begin
      m_buf[m_bytes % 4] = in_byte;
      m_bytes++;
      if (m_bytes % 4 == 0) begin
        if (m_bytes == 4 * DEPTH + 4) begin
          logic [31:0] x;
          x = 32'h0;
          for (int i = 0; i < DEPTH; i++) x ^= m_mem[i];
          m_err = ({m_buf[3], m_buf[2], m_buf[1], m_buf[0]} != x);
          m_active = 0; m_done = 1;
        end else m_pend = 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      int k;
      k = 0;
      for (int i = DEPTH - 1; i >= 0; i--) if (imem[i] !== m_mem[i]) k = i;
      chk("in_ready", 32'(in_ready), 32'(m_active && !m_pend));
      chk("loading", 32'(loading), 32'(m_active));
      chk("load_done", 32'(load_done), 32'(m_done));
      chk("fetch_enable", 32'(fetch_enable), 32'(m_done && !m_err));
      chk("checksum_err", 32'(checksum_err), 32'(m_err));
      chk("word_count", 32'(word_count), 32'(m_wc));
      chk("mem", imem[k], m_mem[k]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int  n;
    logic r;
    n = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
    repeat (n) begin
      in_valid = 1'b0;
      in_byte  = 8'($urandom);
      if (noise) start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_byte  = b;
    for (int t = 0; t < 50; t++) begin
      if (noise) start = 1'($urandom_range(0, 1));
      @(negedge clk); r = in_ready;
      @(posedge clk); #1;
      if (r) begin
        if (mark_first) begin first_cyc = cyc; mark_first = 0; end
        in_valid = 1'b0;
        start    = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk("accept_timeout", 32'd1, 32'd0);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_max);
    for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], gap_max);
  endtask

  task automatic wait_done();
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (load_done) begin done_cyc = cyc; return; end
    end
    chk("done_timeout", 32'd1, 32'd0);
  endtask

  // Load prog[] (already started); checksum word = XOR of prog ^ flip.
  task automatic run_load(input int gap_max, input logic [31:0] flip);
    logic [31:0] x;
    x = 32'h0;
    mark_first = 1;
    for (int w = 0; w < DEPTH; w++) begin
      send_word(prog[w], gap_max);
      x ^= prog[w];
    end
    if (CK) send_word(x ^ flip, gap_max);
    wait_done();
  endtask

  task automatic chk_prog(input string nm);
    for (int i = 0; i < DEPTH; i++) chk(nm, imem[i], prog[i]);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    // Reset then idle
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1;
    for (int i = 0; i < DEPTH; i++) chk("reset_mem", imem[i], 32'h0);
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk("reset_fetch", 32'(fetch_enable), 32'd0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle_wc", 32'(word_count), 32'd0);
    end

    // Full load at full rate
    for (int n = 0; n < DEPTH; n++) prog[n] = 32'hE3A00001 + 32'(n);
    @(posedge clk); #1;
    pulse_start();
    run_load(0, 32'h0);
    chk_prog("full_mem");
    chk("full_latency", 32'(done_cyc - first_cyc + 1), CK ? 32'd69 : 32'd65);
    chk("full_fetch", 32'(fetch_enable), 32'd1);

    // Backpressure and gaps: word 0 bytes with 3-cycle holes between them
    pulse_start();
    mark_first = 0;
    begin
      logic [31:0] x;
      logic [7:0]  bs [4];
      bs[0] = 8'h11; bs[1] = 8'h22; bs[2] = 8'h33; bs[3] = 8'h44;
      for (int b = 0; b < 4; b++) begin
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        send_byte(bs[b], 0);
      end
      prog[0] = 32'h44332211;
      x = prog[0];
      for (int w = 1; w < DEPTH; w++) begin
        prog[w] = $urandom;
        send_word(prog[w], 2);
        x ^= prog[w];
      end
      if (CK) send_word(x, 1);
      wait_done();
    end
    chk("bp_entry0", imem[0], 32'h44332211);
    chk_prog("bp_mem");

    // Reset mid-load after 6 words and a partial word
    pulse_start();
    for (int w = 0; w < 6; w++) send_word($urandom, 1);
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) chk("rst_mid_mem", imem[i], 32'h0);
    chk("rst_mid_done", 32'(load_done), 32'd0);
    chk("rst_mid_loading", 32'(loading), 32'd0);
    chk("rst_mid_wc", 32'(word_count), 32'd0);
    @(posedge clk); #1;
    chk("rst_mid_idle_ready", 32'(in_ready), 32'd0);
    for (int n = 0; n < DEPTH; n++) prog[n] = $urandom;
    pulse_start();
    run_load(0, 32'h0);
    chk_prog("after_rst_mem");

    // Reload from DONE with all-ones words
    pulse_start();
    chk("reload_fetch_fall", 32'(fetch_enable), 32'd0);
    chk("reload_done_fall", 32'(load_done), 32'd0);
    for (int n = 0; n < DEPTH; n++) prog[n] = 32'hFFFFFFFF;
    run_load(1, 32'h0);
    chk_prog("reload_mem");
    chk("reload_fetch", 32'(fetch_enable), 32'd1);

`ifdef INSTR_LOADER_CHECKSUM_EN
    // Checksum good then bad
    for (int n = 0; n < DEPTH; n++) prog[n] = $urandom;
    pulse_start();
    run_load(1, 32'h0);
    chk("ck_good_err", 32'(checksum_err), 32'd0);
    chk("ck_good_fetch", 32'(fetch_enable), 32'd1);
    pulse_start();
    chk("ck_start_clears", 32'(checksum_err), 32'd0);
    run_load(0, 32'h1);
    chk("ck_bad_err", 32'(checksum_err), 32'd1);
    chk("ck_bad_fetch", 32'(fetch_enable), 32'd0);
`endif

    // Randomized loads with gaps and start noise during the load
    noise = 1;
    for (int r = 0; r < 3; r++) begin
      for (int n = 0; n < DEPTH; n++) prog[n] = $urandom;
      pulse_start();
      run_load(3, (r == 1) ? 32'h80 : 32'h0);
      chk("rand_last_entry", imem[DEPTH-1], prog[DEPTH-1]);
      // Extra bytes after DONE must not be accepted
      in_valid = 1'b1; in_byte = 8'h5A;
      repeat (3) begin @(posedge clk); #1; end
      in_valid = 1'b0;
      chk("rand_hold_done", 32'(load_done), 32'd1);
    end
    noise = 0;

    @(negedge clk);
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
